// File: rtl/sc_level_sequencer_pkg.sv
// Shared definitions for the level sequencer and the level counter.
//   state_e : game-state encoding driven on the current-state bus.
//   edge_e  : edge selection for the input edge detectors.
//   SEQ_*_W : default bus widths.
package sc_level_sequencer_pkg;

  localparam int unsigned SEQ_STATE_W = 2;
  localparam int unsigned SEQ_LEVEL_W = 3;

  typedef enum logic [1:0] {
    AWAITSTART = 2'd0,
    STARTGAME  = 2'd1,
    ENDGAME    = 2'd2
  } state_e;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_e;

endpackage

// File: rtl/sc_levelseq_edgedet.sv
// Optional synchronizer chain followed by a single-cycle edge detector.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   d_i     : raw input level
//   pulse_o : one-cycle pulse on the selected edge of the (synchronized) input
// The synchronizer stages reset to SYNC_RESET_VAL; the edge history resets to 0.
module sc_levelseq_edgedet
  import sc_level_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 0,
  parameter logic        SYNC_RESET_VAL = 1'b0,
  parameter edge_e       EDGE           = EDGE_RISE
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  logic sampled;
  logic hist_q;

  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= {SYNC_STAGES{SYNC_RESET_VAL}};
      end else begin
        sync_q[0] <= d_i;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign sampled = sync_q[SYNC_STAGES-1];
  end else begin : g_nosync
    assign sampled = d_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) hist_q <= 1'b0;
    else       hist_q <= sampled;
  end

  // History resets low: a released (high) start line cannot fake a falling edge.
  assign pulse_o = (EDGE == EDGE_FALL) ? (hist_q & ~sampled) : (sampled & ~hist_q);

endmodule

// File: rtl/sc_level_sequencer.sv
// Game-flow controller for the level counter.
//   SC_LEVELCOUNTER_CLOCK_50        : 50 MHz clock
//   SC_LEVELCOUNTER_RESET_InHigh    : asynchronous active-high reset
//   SC_LEVELSEQ_Start_InLow         : raw start button (async, active-low)
//   SC_LEVELSEQ_Goal_InHigh         : frog reached goal (sync level)
//   SC_LEVELSEQ_Collision_InHigh    : frog hit (sync level)
//   SC_LEVELSEQ_Level_InBus         : registered level-counter feedback
//   SC_LEVELSEQ_CurrentState_OutBus : game state (0 await, 1 play, 2 end)
//   SC_LEVELSEQ_CountSignal_OutLow  : one-cycle low strobe advancing the level
//   SC_LEVELSEQ_Lives_OutBus        : remaining lives
//   SC_LEVELSEQ_Won_OutHigh         : game ended in a win
//   SC_LEVELSEQ_Lost_OutHigh        : game ended with lives exhausted
module sc_level_sequencer
  import sc_level_sequencer_pkg::*;
#(
  parameter int unsigned CURRENTSTATE_DATAWIDTH = SEQ_STATE_W,
  parameter int unsigned LEVELCOUNTER_DATAWIDTH = SEQ_LEVEL_W,
  parameter int unsigned MAX_LEVEL              = 3,
  parameter int unsigned LIVES_INIT             = 3,
  parameter int unsigned HOLDOFF_CYCLES         = 16
) (
  input  logic                              SC_LEVELCOUNTER_CLOCK_50,
  input  logic                              SC_LEVELCOUNTER_RESET_InHigh,
  input  logic                              SC_LEVELSEQ_Start_InLow,
  input  logic                              SC_LEVELSEQ_Goal_InHigh,
  input  logic                              SC_LEVELSEQ_Collision_InHigh,
  input  logic [LEVELCOUNTER_DATAWIDTH-1:0] SC_LEVELSEQ_Level_InBus,
  output logic [CURRENTSTATE_DATAWIDTH-1:0] SC_LEVELSEQ_CurrentState_OutBus,
  output logic                              SC_LEVELSEQ_CountSignal_OutLow,
  output logic [2:0]                        SC_LEVELSEQ_Lives_OutBus,
  output logic                              SC_LEVELSEQ_Won_OutHigh,
  output logic                              SC_LEVELSEQ_Lost_OutHigh
);

  localparam int unsigned TIMER_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] HOLDOFF_RELOAD = TIMER_W'(HOLDOFF_CYCLES - 1);
  localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);
  localparam logic [LEVELCOUNTER_DATAWIDTH-1:0] WIN_LEVEL = LEVELCOUNTER_DATAWIDTH'(MAX_LEVEL);

  logic start_p;
  logic goal_p;
  logic coll_p;

  state_e             state_q;
  logic               count_n_q;
  logic [2:0]         lives_q;
  logic               won_q;
  logic               lost_q;
  logic [TIMER_W-1:0] timer_q;

  sc_levelseq_edgedet #(
    .SYNC_STAGES   (2),
    .SYNC_RESET_VAL(1'b1),
    .EDGE          (EDGE_FALL)
  ) u_start_edge (
    .clk_i  (SC_LEVELCOUNTER_CLOCK_50),
    .rst_i  (SC_LEVELCOUNTER_RESET_InHigh),
    .d_i    (SC_LEVELSEQ_Start_InLow),
    .pulse_o(start_p)
  );

  sc_levelseq_edgedet #(
    .SYNC_STAGES   (0),
    .SYNC_RESET_VAL(1'b0),
    .EDGE          (EDGE_RISE)
  ) u_goal_edge (
    .clk_i  (SC_LEVELCOUNTER_CLOCK_50),
    .rst_i  (SC_LEVELCOUNTER_RESET_InHigh),
    .d_i    (SC_LEVELSEQ_Goal_InHigh),
    .pulse_o(goal_p)
  );

  sc_levelseq_edgedet #(
    .SYNC_STAGES   (0),
    .SYNC_RESET_VAL(1'b0),
    .EDGE          (EDGE_RISE)
  ) u_coll_edge (
    .clk_i  (SC_LEVELCOUNTER_CLOCK_50),
    .rst_i  (SC_LEVELCOUNTER_RESET_InHigh),
    .d_i    (SC_LEVELSEQ_Collision_InHigh),
    .pulse_o(coll_p)
  );

  always_ff @(posedge SC_LEVELCOUNTER_CLOCK_50 or posedge SC_LEVELCOUNTER_RESET_InHigh) begin
    if (SC_LEVELCOUNTER_RESET_InHigh) begin
      state_q   <= AWAITSTART;
      count_n_q <= 1'b1;
      lives_q   <= LIVES_LOAD;
      won_q     <= 1'b0;
      lost_q    <= 1'b0;
      timer_q   <= '0;
    end else begin
      count_n_q <= 1'b1;
      case (state_q)
        AWAITSTART: begin
          // Won/Lost remain visible after a game until the next one starts.
          if (start_p) begin
            state_q <= STARTGAME;
            lives_q <= LIVES_LOAD;
            won_q   <= 1'b0;
            lost_q  <= 1'b0;
            timer_q <= '0;
          end
        end
        STARTGAME: begin
          // Reaching the final level pre-empts any same-cycle event, so no
          // strobe or life loss can accompany the move to ENDGAME.
          if (SC_LEVELSEQ_Level_InBus == WIN_LEVEL) begin
            state_q <= ENDGAME;
            won_q   <= 1'b1;
          end else if (timer_q != '0) begin
            timer_q <= timer_q - TIMER_W'(1);
          end else if (coll_p) begin
            timer_q <= HOLDOFF_RELOAD;
            if (lives_q != '0) lives_q <= lives_q - 3'd1;
            if (lives_q <= 3'd1) begin
              state_q <= ENDGAME;
              lost_q  <= 1'b1;
            end
          end else if (goal_p) begin
            count_n_q <= 1'b0;
            timer_q   <= HOLDOFF_RELOAD;
          end
        end
        ENDGAME: begin
          if (start_p) state_q <= AWAITSTART;
        end
        default: state_q <= AWAITSTART;
      endcase
    end
  end

  assign SC_LEVELSEQ_CurrentState_OutBus = CURRENTSTATE_DATAWIDTH'(state_q);
  assign SC_LEVELSEQ_CountSignal_OutLow  = count_n_q;
  assign SC_LEVELSEQ_Lives_OutBus        = lives_q;
  assign SC_LEVELSEQ_Won_OutHigh         = won_q;
  assign SC_LEVELSEQ_Lost_OutHigh        = lost_q;

endmodule

// File: tb/tb_sc_level_sequencer.sv
module tb_sc_level_sequencer;

  localparam int HOLD  = 16;
  localparam int MAXL  = 3;
  localparam int LIVES = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_n;
  logic       goal;
  logic       coll;
  logic [2:0] level;
  logic [1:0] state;
  logic       count_n;
  logic [2:0] lives;
  logic       won;
  logic       lost;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int strobes = 0;
  int bad_strobes = 0;

  // Reference game state
  int m_state, m_lives, m_level, m_won, m_lost, last_acc, exp_strobes;
  int kind, gap, e;

  sc_level_sequencer #(
    .CURRENTSTATE_DATAWIDTH(2),
    .LEVELCOUNTER_DATAWIDTH(3),
    .MAX_LEVEL             (MAXL),
    .LIVES_INIT            (LIVES),
    .HOLDOFF_CYCLES        (HOLD)
  ) dut (
    .SC_LEVELCOUNTER_CLOCK_50       (clk),
    .SC_LEVELCOUNTER_RESET_InHigh   (rst),
    .SC_LEVELSEQ_Start_InLow        (start_n),
    .SC_LEVELSEQ_Goal_InHigh        (goal),
    .SC_LEVELSEQ_Collision_InHigh   (coll),
    .SC_LEVELSEQ_Level_InBus        (level),
    .SC_LEVELSEQ_CurrentState_OutBus(state),
    .SC_LEVELSEQ_CountSignal_OutLow (count_n),
    .SC_LEVELSEQ_Lives_OutBus       (lives),
    .SC_LEVELSEQ_Won_OutHigh        (won),
    .SC_LEVELSEQ_Lost_OutHigh       (lost)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Level counter environment: advances on each low strobe, clears while awaiting start.
  always @(posedge clk or posedge rst) begin
    if (rst)                level <= 3'd0;
    else if (state == 2'd0) level <= 3'd0;
    else if (!count_n)      level <= level + 3'd1;
  end

  always @(negedge clk) begin
    if (!count_n) strobes <= strobes + 1;
    if (!count_n && state != 2'd1) bad_strobes <= bad_strobes + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press_start();
    start_n = 1'b0;
    tick(4);
    start_n = 1'b1;
    tick(4);
  endtask

  task automatic goal_pulse();
    goal = 1'b1;
    tick(1);
    goal = 1'b0;
  endtask

  task automatic coll_pulse();
    coll = 1'b1;
    tick(1);
    coll = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_n = 1'b1; goal = 1'b0; coll = 1'b0;
    exp_strobes = 0;
    tick(2);
    check("rst_state", state, 0);
    check("rst_count", count_n, 1);
    check("rst_lives", lives, LIVES);
    check("rst_won", won, 0);
    check("rst_lost", lost, 0);
    rst = 1'b0;
    tick(1);

    // Start press: STARTGAME on third edge
    start_n = 1'b0;
    tick(2);
    check("start_edge2", state, 0);
    tick(1);
    check("start_edge3", state, 1);
    check("start_lives", lives, LIVES);
    check("start_count", count_n, 1);
    tick(1);
    start_n = 1'b1;
    tick(4);

    // First goal: one strobe, level 0->1
    goal = 1'b1;
    tick(1);
    check("goal1_strobe", count_n, 0);
    goal = 1'b0;
    tick(1);
    check("goal1_release", count_n, 1);
    check("goal1_level", level, 1);
    exp_strobes++;
    check("goal1_strobes", strobes, exp_strobes);

    // Second goal inside hold-off is dropped
    tick(3);
    goal = 1'b1;
    tick(1);
    check("holdoff_nostrobe", count_n, 1);
    goal = 1'b0;
    tick(1);
    check("holdoff_level", level, 1);

    // Goal after hold-off gives level 2
    tick(20);
    goal_pulse();
    exp_strobes++;
    tick(1);
    check("goal2_level", level, 2);

    // Third goal: win two edges after the strobe
    tick(20);
    goal = 1'b1;
    tick(1);
    check("goal3_strobe", count_n, 0);
    goal = 1'b0;
    exp_strobes++;
    tick(1);
    check("goal3_level", level, 3);
    check("goal3_state_n1", state, 1);
    tick(1);
    check("win_state", state, 2);
    check("win_won", won, 1);
    check("win_lost", lost, 0);
    check("win_strobes", strobes, exp_strobes);

    // Start in ENDGAME returns to AWAITSTART, Won held until next game
    press_start();
    check("end_to_await", state, 0);
    check("await_won_held", won, 1);
    press_start();
    check("restart_state", state, 1);
    check("restart_won", won, 0);
    check("restart_lives", lives, LIVES);

    // Three collisions: lose
    tick(2);
    coll_pulse();
    check("coll1_lives", lives, 2);
    check("coll1_count", count_n, 1);
    tick(20);
    coll_pulse();
    check("coll2_lives", lives, 1);
    tick(20);
    coll_pulse();
    check("coll3_lives", lives, 0);
    check("lose_state", state, 2);
    check("lose_lost", lost, 1);
    check("lose_won", won, 0);
    check("lose_strobes", strobes, exp_strobes);

    // Goal and collision together: collision wins, hold-off starts
    press_start();
    press_start();
    check("restart2_lost", lost, 0);
    tick(2);
    goal = 1'b1; coll = 1'b1;
    tick(1);
    check("both_lives", lives, 2);
    check("both_nostrobe", count_n, 1);
    goal = 1'b0; coll = 1'b0;
    tick(4);
    goal_pulse();
    check("both_holdoff", count_n, 1);
    tick(1);
    check("both_level", level, 0);
    check("both_strobes", strobes, exp_strobes);

    // Reset during a strobe
    tick(20);
    goal = 1'b1;
    tick(1);
    check("pre_rst_strobe", count_n, 0);
    rst = 1'b1;
    #1;
    check("midrst_count", count_n, 1);
    check("midrst_state", state, 0);
    check("midrst_lives", lives, LIVES);
    goal = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    check("midrst_strobes", strobes, exp_strobes);

    // Randomized play against the game-rule model
    press_start();
    m_state = 1; m_lives = LIVES; m_level = 0; m_won = 0; m_lost = 0; last_acc = -1000;
    for (int ev = 0; ev < 60; ev++) begin
      kind = $urandom_range(0, 2);
      gap  = $urandom_range(1, 20);
      tick(gap);
      goal = (kind != 1);
      coll = (kind != 0);
      tick(1);
      e = cyc;
      goal = 1'b0; coll = 1'b0;
      if (m_state == 1 && (e - last_acc) >= HOLD) begin
        last_acc = e;
        if (kind != 0) begin
          m_lives--;
          if (m_lives == 0) begin m_state = 2; m_lost = 1; end
        end else begin
          m_level++;
          exp_strobes++;
          if (m_level == MAXL) begin m_state = 2; m_won = 1; end
        end
      end
      tick(3);
      check("rnd_state", state, m_state);
      check("rnd_lives", lives, m_lives);
      check("rnd_level", level, m_level);
      check("rnd_won", won, m_won);
      check("rnd_lost", lost, m_lost);
      check("rnd_strobes", strobes, exp_strobes);
      if (m_state == 2) begin
        press_start();
        press_start();
        m_state = 1; m_lives = LIVES; m_level = 0; m_won = 0; m_lost = 0; last_acc = -1000;
      end
    end

    check("no_stray_strobe", bad_strobes, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
